// File: rtl/apb_slave_regfile_if.sv
// APB bus bundle shared by the completer and its master; psel..pwdata come from the master,
// prdata/pready/pslverr come back from the completer.
interface apb_slave_regfile_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
);
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [ADDR_WIDTH-1:0] paddr;
  logic [DATA_WIDTH-1:0] pwdata;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pready;
  logic                  pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_slave_regfile.sv
// APB completer backed by a DEPTH-entry register file with WAIT_STATES wait cycles per access.
// Optional macro APB_SLVERR_EN: flag out-of-range accesses with pslverr (otherwise pslverr = 0).
//
// state   | meaning
// S_IDLE  | no transfer; waiting for a setup phase
// S_WAIT  | access phase, pready low, counting down wait states
// S_READY | pready high; completion edge commits a write
module apb_slave_regfile #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 8,
  parameter int DEPTH       = 64,
  parameter int WAIT_STATES = 0
) (
  input  logic                  pclk,
  input  logic                  presetn,
  apb_slave_regfile_if.slave    bus
);

  localparam int         IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [2:0] WS    = 3'(WAIT_STATES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_READY} state_t;

  state_t                r_state;
  logic [2:0]            r_cnt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_write;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_prdata;
  logic                  r_pready;
  logic                  r_pslverr;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic                  w_setup;
  logic                  w_access;
  logic                  w_take_setup;
  logic [ADDR_WIDTH-1:0] w_ld_addr;
  logic                  w_ld_write;
  logic                  w_ld_in_range;
  logic [DATA_WIDTH-1:0] w_ld_rdata;
  logic                  w_ld_err;
  logic                  w_enter_ready;
  logic                  w_cur_in_range;
  logic                  w_commit;

  assign w_setup      = bus.psel & ~bus.penable;
  assign w_access     = bus.psel &  bus.penable;
  assign w_take_setup = w_setup & ((r_state == S_IDLE) | (r_state == S_READY));

  // With zero wait states READY is entered on the setup edge, so the response must use the bus
  // address directly rather than the not-yet-latched copy.
  assign w_ld_addr     = w_take_setup ? bus.paddr  : r_addr;
  assign w_ld_write    = w_take_setup ? bus.pwrite : r_write;
  assign w_ld_in_range = 32'(w_ld_addr) < 32'(DEPTH);
  assign w_ld_rdata    = w_ld_in_range ? r_mem[w_ld_addr[IDX_W-1:0]] : '0;

`ifdef APB_SLVERR_EN
  assign w_ld_err = ~w_ld_in_range;
`else
  assign w_ld_err = 1'b0;
`endif

  assign w_enter_ready = (w_take_setup & (WS == 3'd0)) |
                         ((r_state == S_WAIT) & w_access & (r_cnt == 3'd1));

  assign w_cur_in_range = 32'(r_addr) < 32'(DEPTH);
  assign w_commit       = (r_state == S_READY) & w_access & r_pready & r_write &
                          w_cur_in_range & ~r_pslverr;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_state   <= S_IDLE;
      r_cnt     <= 3'd0;
      r_addr    <= '0;
      r_write   <= 1'b0;
      r_wdata   <= '0;
      r_prdata  <= '0;
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE:  r_state <= S_IDLE;
        S_WAIT: begin
          if (w_access) begin
            r_cnt <= r_cnt - 3'd1;
            if (r_cnt == 3'd1) r_state <= S_READY;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_READY: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase

      // A setup seen in IDLE, or right behind a READY cycle, starts a new transfer.
      if (w_take_setup) begin
        r_addr  <= bus.paddr;
        r_write <= bus.pwrite;
        r_wdata <= bus.pwdata;
        r_cnt   <= WS;
        r_state <= (WS == 3'd0) ? S_READY : S_WAIT;
      end

      if (w_enter_ready) begin
        r_pready  <= 1'b1;
        r_pslverr <= w_ld_err;
        if (!w_ld_write) r_prdata <= w_ld_rdata;
      end else begin
        r_pready  <= 1'b0;
        r_pslverr <= 1'b0;
      end
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_commit) begin
      r_mem[r_addr[IDX_W-1:0]] <= r_wdata;
    end
  end

  assign bus.prdata  = r_prdata;
  assign bus.pready  = r_pready;
  assign bus.pslverr = r_pslverr;

endmodule
